// File: rtl/mem_morpher_arbiter.sv
// mem_morpher_arbiter: round-robin sharing of the morpher's single line-read port among NREQ requesters,
// one outstanding line at a time, with the returned line held until the winner accepts it.
module mem_morpher_arbiter #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 256
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid_i,
    output logic [NREQ-1:0]        req_ready_o,
    input  logic [NREQ*ADDR_W-1:0] req_addr_i,
    output logic [NREQ-1:0]        resp_valid_o,
    input  logic [NREQ-1:0]        resp_ready_i,
    output logic [DATA_W-1:0]      resp_data_o,
    output logic                   mem_valid_o,
    output logic [ADDR_W-1:0]      mem_addr_o,
    input  logic [DATA_W-1:0]      mem_data_i,
    output logic                   busy_o
);
    localparam int IW = $clog2(NREQ);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t              state_q, state_d;
    logic [IW-1:0]       gnt_q, gnt_d, rr_q, rr_d, win;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                found;
    int                  j;
    // Scan from rr_q upward with wrap; first valid requester wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req_valid_i[j]) begin
                found = 1'b1;
                win   = IW'(j);
            end
        end
    end
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: if (found) begin
                state_d = ISSUE;
                gnt_d   = win;
                rr_d    = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
                addr_d  = {req_addr_i[int'(win)*ADDR_W + 5 +: ADDR_W - 5], 5'b0};
            end
            ISSUE: begin
                state_d = RESP;
                data_d  = mem_data_i;
            end
            RESP: if (resp_ready_i[gnt_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end
    assign req_ready_o  = (state_q == IDLE && found) ? NREQ'(1) << win : '0;
    assign resp_valid_o = (state_q == RESP) ? NREQ'(1) << gnt_q : '0;
    assign mem_valid_o  = (state_q == ISSUE);
    assign mem_addr_o   = addr_q;
    assign resp_data_o  = data_q;
    assign busy_o       = (state_q != IDLE);
endmodule

// File: tb/tb_mem_morpher_arbiter.sv
// tb_mem_morpher_arbiter: directed scenarios plus random traffic, every cycle compared against a
// transaction-level reference model of the arbiter.
module tb_mem_morpher_arbiter;
    localparam int N = 3, AW = 64, DW = 256;
    logic clock = 1'b0, reset = 1'b0;
    logic [N-1:0]    req_valid = '0, req_ready, resp_valid, resp_ready = '1;
    logic [N*AW-1:0] req_addr = '0;
    logic [DW-1:0]   resp_data, mem_data = '0;
    logic            mem_valid, busy;
    logic [AW-1:0]   mem_addr;
    bit              hold = 1'b0;
    int checks = 0, failures = 0, cyc = 0;
    // reference model: phase 0 idle, 1 read issued, 2 line waiting for its owner
    int m_phase = 0, m_g = 0, m_rr = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_line = '0;
    // observations for the directed scenarios
    int mv_cnt, rv_cnt, mv_t, rv_first, hs_t, gq[$], gt[$];
    logic [AW-1:0] last_ma;
    logic [DW-1:0] last_rd;

    mem_morpher_arbiter #(.NREQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_data_o(resp_data),
        .mem_valid_o(mem_valid), .mem_addr_o(mem_addr), .mem_data_i(mem_data),
        .busy_o(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        mv_cnt = 0; rv_cnt = 0; mv_t = -1; rv_first = -1; hs_t = -1;
        gq.delete(); gt.delete();
    endtask

    task automatic cycle();
        int win;
        logic [N-1:0] e_rdy, e_rv, acc;
        #1;
        win = -1;
        if (m_phase == 0)
            for (int k = 0; k < N; k++)
                if (win < 0 && req_valid[(m_rr + k) % N]) win = (m_rr + k) % N;
        e_rdy = (win >= 0) ? N'(1) << win : '0;
        e_rv  = (m_phase == 2) ? N'(1) << m_g : '0;
        chk("req_ready", DW'(req_ready), DW'(e_rdy));
        chk("resp_valid", DW'(resp_valid), DW'(e_rv));
        chk("mem_valid", DW'(mem_valid), DW'(m_phase == 1));
        chk("mem_addr", DW'(mem_addr), DW'(m_addr));
        chk("resp_data", resp_data, m_line);
        chk("busy", DW'(busy), DW'(m_phase != 0));
        acc = req_ready;
        for (int i = 0; i < N; i++)
            if (req_ready[i]) begin gq.push_back(i); gt.push_back(cyc); end
        if (mem_valid) begin mv_cnt++; mv_t = cyc; last_ma = mem_addr; end
        if (|resp_valid) begin
            rv_cnt++;
            last_rd = resp_data;
            if (rv_first < 0) rv_first = cyc;
        end
        if (|(resp_valid & resp_ready) && hs_t < 0) hs_t = cyc;
        if (!reset) begin
            m_phase = 0; m_rr = 0; m_g = 0; m_addr = '0; m_line = '0;
        end else if (m_phase == 0) begin
            if (win >= 0) begin
                m_g = win;
                m_addr = req_addr[win*AW +: AW] & ~AW'(31);
                m_rr = (win + 1) % N;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_line = mem_data;
            m_phase = 2;
        end else if (resp_ready[m_g]) m_phase = 0;
        @(posedge clock);
        #1;
        cyc++;
        if (!hold) req_valid = req_valid & ~acc;
    endtask

    task automatic do_reset();
        reset = 1'b0; req_valid = '0; resp_ready = '1; hold = 1'b0;
        cycle(); cycle();
        reset = 1'b1;
    endtask

    initial begin
        @(posedge clock);
        #1;
        do_reset();

        // single aligned request
        clr();
        req_addr[0 +: AW] = 64'h8000_0040;
        for (int k = 0; k < 32; k++) mem_data[8*k +: 8] = 8'(k);
        req_valid = 3'b001;
        for (int i = 0; i < 6; i++) cycle();
        chk("s1_grants", DW'(gq.size()), DW'(1));
        chk("s1_mv_cnt", DW'(mv_cnt), DW'(1));
        chk("s1_mem_addr", DW'(last_ma), DW'(64'h8000_0040));
        chk("s1_byte0", DW'(last_rd[7:0]), DW'(8'h00));
        chk("s1_byte31", DW'(last_rd[255:248]), DW'(8'h1F));
        if (gt.size() > 0) begin
            chk("s1_mv_lat", DW'(mv_t), DW'(gt[0] + 1));
            chk("s1_rv_lat", DW'(rv_first), DW'(gt[0] + 2));
        end

        // unaligned request returns the containing line
        clr();
        req_addr[0 +: AW] = 64'h8000_005B;
        req_valid = 3'b001;
        for (int i = 0; i < 6; i++) cycle();
        chk("s2_mv_cnt", DW'(mv_cnt), DW'(1));
        chk("s2_mem_addr", DW'(last_ma), DW'(64'h8000_0040));

        // simultaneous start, then pointer back at 0
        do_reset();
        clr();
        req_addr[AW +: AW] = 64'h1234_5678_9ABC_DEF7;
        req_valid = 3'b011;
        for (int i = 0; i < 8; i++) cycle();
        req_valid = 3'b011;
        for (int i = 0; i < 3; i++) cycle();
        chk("s3_grants", DW'(gq.size()), DW'(3));
        if (gq.size() == 3) begin
            chk("s3_first", DW'(gq[0]), DW'(0));
            chk("s3_second", DW'(gq[1]), DW'(1));
            chk("s3_wrap", DW'(gq[2]), DW'(0));
        end
        for (int i = 0; i < 6; i++) cycle();

        // fairness with all three continuously requesting
        do_reset();
        clr();
        hold = 1'b1;
        req_valid = 3'b111;
        for (int i = 0; i < 18; i++) cycle();
        hold = 1'b0;
        req_valid = '0;
        chk("s4_grants", DW'(gq.size()), DW'(6));
        if (gq.size() >= 6)
            for (int i = 0; i < 6; i++) begin
                chk("s4_order", DW'(gq[i]), DW'(i % 3));
                if (i > 0) chk("s4_spacing", DW'(gt[i] - gt[i-1]), DW'(3));
            end
        for (int i = 0; i < 4; i++) cycle();

        // backpressure: five stalled RESP cycles while requester 1 waits
        do_reset();
        clr();
        resp_ready = '0;
        req_valid = 3'b011;
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (rv_cnt == 5) resp_ready = '1;
        end
        chk("s5_grants", DW'(gq.size()), DW'(2));
        chk("s5_stall", DW'(hs_t - rv_first), DW'(5));
        if (gq.size() == 2) begin
            chk("s5_next_id", DW'(gq[1]), DW'(1));
            chk("s5_next_t", DW'(gt[1]), DW'(hs_t + 1));
        end

        // reset asserted during ISSUE
        do_reset();
        clr();
        req_addr[0 +: AW] = 64'hDEAD_BEEF_0000_1010;
        req_valid = 3'b001;
        cycle();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        chk("s6_no_resp", DW'(rv_cnt), DW'(0));
        chk("s6_one_strobe", DW'(mv_cnt), DW'(1));
        clr();
        req_valid = 3'b011;
        for (int i = 0; i < 6; i++) cycle();
        chk("s6_fresh_cnt", DW'(gq.size()), DW'(2));
        if (gq.size() > 0) chk("s6_fresh_first", DW'(gq[0]), DW'(0));
        chk("s6_fresh_resp", DW'(rv_cnt > 0), DW'(1));

        // random traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++)
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_addr[i*AW +: AW] = {$urandom, $urandom};
                    req_valid[i] = 1'b1;
                end
            resp_ready = N'($urandom);
            for (int k = 0; k < 8; k++) mem_data[32*k +: 32] = $urandom;
            reset = ($urandom_range(0, 49) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
